// File: rtl/dac_multi_channel_ctrl.sv
// Serial-command DAC controller: receives a channel number and a DAC code as
// a stream of bit strobes, issues one 3-byte I2C write per command and keeps
// a readable shadow copy of the last code written to every channel.
module dac_multi_channel_ctrl #(
   parameter int         DATA_W      = 10,
   parameter int         NUM_CH      = 4,
   parameter int         CH_W        = 2,
   parameter logic [6:0] I2C_ADDR    = 7'b0001101,
   parameter int         ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_v,
   input  logic              set_v_1,
   input  logic              set_v_0,
   input  logic              abort,
   output logic [6:0]        i2c_addr,
   output logic [23:0]       i2c_data,
   output logic [1:0]        i2c_nbytes,
   output logic              i2c_r_w,
   output logic              i2c_load,
   input  logic              i2c_busy,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [DATA_W-1:0] rd_code,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // one shift register serves both the channel field and the code field
   localparam int SH_W  = (DATA_W > CH_W) ? DATA_W : CH_W;
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RX_CH     = 3'd1,
      RX_DATA   = 3'd2,
      WAIT_BUS  = 3'd3,
      LOAD      = 3'd4,
      WAIT_ACK  = 3'd5,
      WAIT_DONE = 3'd6
   } state_t;

   state_t              state_r;
   state_t              next_s;
   logic [4:0]          bit_cnt_r;
   logic [SH_W-1:0]     sh_r;
   logic [SH_W-1:0]     sh_shift_s;
   logic [CH_W-1:0]     ch_r;
   logic [DATA_W-1:0]   code_r;
   logic [TMO_W-1:0]    tmo_r;
   logic [23:0]         i2c_data_r;
   logic                load_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic                bit_ev_s;
   logic                last_ch_s;
   logic                last_data_s;
   logic                ch_ok_s;
   logic                tmo_hit_s;
   logic                done_s;
   logic                err_s;
   logic [DATA_W-1:0]   shadow_r [NUM_CH];

   // a bit event is exactly one of the two strobes; both together is noise
   assign bit_ev_s    = set_v_1 ^ set_v_0;
   assign sh_shift_s  = SH_W'({sh_r, set_v_1});
   assign last_ch_s   = (bit_cnt_r == 5'(CH_W - 1));
   assign last_data_s = (bit_cnt_r == 5'(DATA_W - 1));
   assign ch_ok_s     = (32'(sh_shift_s[CH_W-1:0]) < 32'(NUM_CH));
   // the error pulse lands ACK_TIMEOUT cycles after the i2c_load cycle
   assign tmo_hit_s   = ((int'(tmo_r) + 32'sd2) >= ACK_TIMEOUT);

   assign i2c_addr   = I2C_ADDR;
   assign i2c_nbytes = 2'd3;
   assign i2c_r_w    = 1'b0;
   assign i2c_data   = i2c_data_r;
   assign i2c_load   = load_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;

   // next-state decode; abort overrides every other transition
   always_comb begin
      next_s = state_r;
      done_s = 1'b0;
      err_s  = 1'b0;
      if (abort) begin
         next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (set_v) next_s = RX_CH;
               else       next_s = IDLE;
            end
            RX_CH: begin
               if (bit_ev_s && last_ch_s) begin
                  if (ch_ok_s) begin
                     next_s = RX_DATA;
                  end else begin
                     err_s  = 1'b1;
                     next_s = IDLE;
                  end
               end else begin
                  next_s = RX_CH;
               end
            end
            RX_DATA: begin
               if (bit_ev_s && last_data_s) next_s = WAIT_BUS;
               else                         next_s = RX_DATA;
            end
            WAIT_BUS: begin
               if (!i2c_busy) next_s = LOAD;
               else           next_s = WAIT_BUS;
            end
            LOAD: begin
               next_s = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (i2c_busy) begin
                  next_s = WAIT_DONE;
               end else if (tmo_hit_s) begin
                  err_s  = 1'b1;
                  next_s = IDLE;
               end else begin
                  next_s = WAIT_ACK;
               end
            end
            WAIT_DONE: begin
               if (!i2c_busy) begin
                  done_s = 1'b1;
                  next_s = IDLE;
               end else begin
                  next_s = WAIT_DONE;
               end
            end
            default: next_s = IDLE;
         endcase
      end
   end

   // state register and registered status outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         load_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= next_s;
         load_r  <= (next_s == LOAD);
         busy_r  <= (next_s != IDLE);
         done_r  <= done_s;
         err_r   <= err_s;
      end
   end

   // bit reception, command capture and the acknowledge timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r  <= 5'd0;
         sh_r       <= {SH_W{1'b0}};
         ch_r       <= {CH_W{1'b0}};
         code_r     <= {DATA_W{1'b0}};
         tmo_r      <= {TMO_W{1'b0}};
         i2c_data_r <= 24'd0;
      end else if (abort) begin
         bit_cnt_r <= 5'd0;
         sh_r      <= {SH_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (set_v) begin
                  bit_cnt_r <= 5'd0;
                  sh_r      <= {SH_W{1'b0}};
               end
            end
            RX_CH: begin
               if (bit_ev_s) begin
                  if (last_ch_s) begin
                     ch_r      <= sh_shift_s[CH_W-1:0];
                     sh_r      <= {SH_W{1'b0}};
                     bit_cnt_r <= 5'd0;
                  end else begin
                     sh_r      <= sh_shift_s;
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                  end
               end
            end
            RX_DATA: begin
               if (bit_ev_s) begin
                  if (last_data_s) begin
                     code_r     <= sh_shift_s[DATA_W-1:0];
                     i2c_data_r <= {8'(8'h01 << ch_r),
                                    16'(16'(sh_shift_s[DATA_W-1:0]) << (16 - DATA_W))};
                     sh_r       <= {SH_W{1'b0}};
                     bit_cnt_r  <= 5'd0;
                  end else begin
                     sh_r      <= sh_shift_s;
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                  end
               end
            end
            LOAD:     tmo_r <= {TMO_W{1'b0}};
            WAIT_ACK: tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
            default: ;
         endcase
      end
   end

   // shadow copy is updated only when a write completes successfully
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) shadow_r[i] <= {DATA_W{1'b0}};
      end else if (done_s) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_r == CH_W'(i)) shadow_r[i] <= code_r;
         end
      end
   end

   // shadow readback; channels beyond NUM_CH read as zero
   always_comb begin
      rd_code = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         rd_code = rd_code | ((rd_ch == CH_W'(i)) ? shadow_r[i] : {DATA_W{1'b0}});
      end
   end

endmodule

// File: tb/tb_dac_multi_channel_ctrl.sv
// Bench for dac_multi_channel_ctrl: a 4-channel and a 3-channel instance share
// all stimulus; a per-channel shadow model predicts data, pulses and readback.
module tb_dac_multi_channel_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, set_v, set_v_1, set_v_0, abort, i2c_busy;
   logic [1:0]  rd_ch;
   logic [6:0]  a_addr, b_addr;
   logic [23:0] a_data, b_data;
   logic [1:0]  a_nb, b_nb;
   logic        a_rw, b_rw, a_load, b_load, a_busy, b_busy;
   logic        a_done, b_done, a_err, b_err;
   logic [9:0]  a_rd, b_rd;

   int total = 0;
   int bad   = 0;
   int load_cnt_a = 0;
   int load_cnt_b = 0;
   logic [9:0] mdl_a [4];
   logic [9:0] mdl_b [4];

   dac_multi_channel_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .set_v(set_v), .set_v_1(set_v_1), .set_v_0(set_v_0),
      .abort(abort), .i2c_addr(a_addr), .i2c_data(a_data), .i2c_nbytes(a_nb),
      .i2c_r_w(a_rw), .i2c_load(a_load), .i2c_busy(i2c_busy), .rd_ch(rd_ch),
      .rd_code(a_rd), .busy(a_busy), .done(a_done), .err(a_err));

   dac_multi_channel_ctrl #(.NUM_CH(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .set_v(set_v), .set_v_1(set_v_1), .set_v_0(set_v_0),
      .abort(abort), .i2c_addr(b_addr), .i2c_data(b_data), .i2c_nbytes(b_nb),
      .i2c_r_w(b_rw), .i2c_load(b_load), .i2c_busy(i2c_busy), .rd_ch(rd_ch),
      .rd_code(b_rd), .busy(b_busy), .done(b_done), .err(b_err));

   // free-running clock
   always #5 clk = ~clk;

   // count i2c_load pulses of both instances
   always @(posedge clk) begin
      if (a_load === 1'b1) load_cnt_a <= load_cnt_a + 1;
      if (b_load === 1'b1) load_cnt_b <= load_cnt_b + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_models();
      for (int c = 0; c < 4; c++) begin
         mdl_a[c] = 10'd0;
         mdl_b[c] = 10'd0;
      end
   endtask

   // compare readback of every channel select against the model
   task automatic check_rd(input string tag);
      for (int c = 0; c < 4; c++) begin
         rd_ch = 2'(c);
         #1;
         check_eq({tag, "_rd_a"}, a_rd, mdl_a[c]);
         check_eq({tag, "_rd_b"}, b_rd, (c < 3) ? mdl_b[c] : 10'd0);
      end
   endtask

   // shift n bits MSB first; gaps may carry ignored both-high strobes
   task automatic send_bits(input logic [15:0] v, input int n, input bit force_dbl);
      for (int i = n - 1; i >= 0; i--) begin
         int gap;
         gap = force_dbl ? 2 : $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            set_v_1 = force_dbl ? 1'b1 : 1'($urandom_range(0, 1));
            set_v_0 = set_v_1;
            tick();
         end
         set_v_1 = v[i];
         set_v_0 = ~v[i];
         tick();
         set_v_1 = 1'b0;
         set_v_0 = 1'b0;
      end
   endtask

   task automatic start_cmd();
      set_v = 1'b1;
      tick();
      set_v = 1'b0;
   endtask

   // one full command: channel, code, bus response; tmo means the bus never answers
   task automatic do_write(input logic [1:0] ch, input logic [9:0] code, input int rise,
                           input int hold, input int pre_hold, input bit tmo, input bit dbl);
      int la, lb, n;
      bit b_ok;
      logic [23:0] exp_d;
      la = load_cnt_a;
      lb = load_cnt_b;
      b_ok = (ch != 2'd3);
      exp_d = {8'h01 << ch, code, 6'b000000};
      start_cmd();
      send_bits({14'd0, ch}, 2, 1'b0);
      check_eq("err_a_ch", a_err, 0);
      check_eq("err_b_ch", b_err, !b_ok);
      if (pre_hold > 0) i2c_busy = 1'b1;
      send_bits({6'd0, code}, 10, dbl);
      check_eq("data_a", a_data, exp_d);
      if (b_ok) check_eq("data_b", b_data, exp_d);
      else      check_eq("idle_b", b_busy, 0);
      for (int i = 0; i < pre_hold; i++) begin
         check_eq("load_held", a_load, 0);
         tick();
      end
      i2c_busy = 1'b0;
      tick();
      check_eq("load_a", a_load, 1);
      check_eq("load_b", b_load, b_ok);
      if (tmo) begin
         n = 0;
         while (n < 400 && a_err !== 1'b1) begin
            tick();
            n++;
         end
         check_eq("tmo_cycles", n, 255);
         check_eq("tmo_busy", a_busy, 0);
         check_eq("tmo_done", a_done, 0);
      end else begin
         repeat (rise) tick();
         i2c_busy = 1'b1;
         repeat (hold) tick();
         check_eq("busy_txn", a_busy, 1);
         i2c_busy = 1'b0;
         tick();
         check_eq("done_a", a_done, 1);
         check_eq("done_b", b_done, b_ok);
         tick();
         check_eq("done_pulse", a_done, 0);
         mdl_a[ch] = code;
         if (b_ok) mdl_b[ch] = code;
      end
      check_eq("loads_a", load_cnt_a - la, 1);
      check_eq("loads_b", load_cnt_b - lb, b_ok);
      check_rd("wr");
   endtask

   initial begin
      rst_n = 1'b0; set_v = 1'b0; set_v_1 = 1'b0; set_v_0 = 1'b0;
      abort = 1'b0; i2c_busy = 1'b0; rd_ch = 2'd0;
      clear_models();
      repeat (3) tick();
      check_eq("rst_busy", a_busy, 0);
      check_eq("rst_load", a_load, 0);
      check_eq("rst_done", a_done, 0);
      check_eq("rst_err", a_err, 0);
      check_eq("rst_data", a_data, 24'd0);
      check_eq("addr", a_addr, 7'h0D);
      check_eq("nbytes", a_nb, 2'd3);
      check_eq("r_w", a_rw, 0);
      check_rd("rst");
      rst_n = 1'b1;
      tick();

      // bits without a command are ignored
      send_bits(16'h5A5A, 8, 1'b0);
      check_eq("idle_bits", a_busy, 0);

      // reference write: channel 2, code 0x201
      do_write(2'd2, 10'h201, 3, 20, 0, 1'b0, 1'b0);
      check_eq("ref_data", a_data, 24'h048040);

      // invalid channel for the 3-channel instance
      do_write(2'd3, 10'h155, 2, 4, 0, 1'b0, 1'b0);

      // bus busy at command end for 50 cycles
      do_write(2'd1, 10'h0F3, 1, 6, 50, 1'b0, 1'b0);

      // no acknowledge from the bus
      do_write(2'd1, 10'h2AA, 0, 0, 0, 1'b1, 1'b0);

      // both-high strobes between every data bit
      do_write(2'd0, 10'h1C7, 2, 3, 0, 1'b0, 1'b1);

      // abort after five data bits, then a full write to channel 0
      start_cmd();
      send_bits(16'd0, 2, 1'b0);
      send_bits(16'h0015, 5, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", a_busy, 0);
      check_eq("abort_err", a_err, 0);
      check_eq("abort_done", a_done, 0);
      send_bits(16'h001F, 5, 1'b0);
      check_eq("abort_stay", a_busy, 0);
      do_write(2'd0, 10'h3FF, 3, 5, 0, 1'b0, 1'b0);

      // randomized commands
      for (int k = 0; k < 24; k++) begin
         do_write(2'($urandom_range(0, 3)), 10'($urandom), $urandom_range(0, 6),
                  $urandom_range(1, 8), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                  1'b0, 1'b0);
      end

      // reset pulse in the middle of the data field
      start_cmd();
      send_bits(16'd3, 2, 1'b0);
      send_bits(16'h000B, 4, 1'b0);
      rst_n = 1'b0;
      #2;
      clear_models();
      check_eq("mrst_busy", a_busy, 0);
      check_eq("mrst_data", a_data, 24'd0);
      check_eq("mrst_load", a_load, 0);
      check_eq("mrst_err", a_err, 0);
      check_eq("mrst_done", a_done, 0);
      check_rd("mrst");
      tick();
      rst_n = 1'b1;
      tick();
      send_bits(16'h03C3, 10, 1'b0);
      check_eq("mrst_idle", a_busy, 0);
      check_eq("mrst_noload", a_load, 0);
      do_write(2'd2, 10'h2D6, 1, 2, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
